// File: rtl/fnd_pkg.sv
// Shared constants for the 4-digit common-anode FND scan controller.
// All codes are active-low, matching the board pins.
package fnd_pkg;

   localparam logic [3:0] COM_OFF = 4'b1111;

   localparam logic [3:0] COM_CODE [0:3] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

   // {dp,g,f,e,d,c,b,a}, dp off
   localparam logic [7:0] FONT_DIGIT [0:9] = '{
      8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
      8'h92, 8'h82, 8'hF8, 8'h80, 8'h90
   };

   localparam logic [7:0] FONT_DASH  = 8'hBF;
   localparam logic [7:0] FONT_BLANK = 8'hFF;
   localparam int         DP_BIT     = 7;

endpackage

// File: rtl/fnd_bcd_decoder.sv
// BCD nibble to active-low 7-segment pattern {g,f,e,d,c,b,a}.
// Non-decimal nibbles render as a dash.
module fnd_bcd_decoder
   import fnd_pkg::*;
(
   input  logic [3:0] bcd,
   output logic [6:0] seg
);

   always_comb begin
      seg = FONT_DASH[6:0];
      if (bcd < 4'd10) seg = FONT_DIGIT[bcd][6:0];
   end

endmodule

// File: rtl/fnd_scan_ctrl.sv
// 4-digit FND scan controller: one digit per slot, source/BCD latched once per
// frame, leading-zero blanking for ultrasonic data, blinking dot for stopwatch.
//
// idx | meaning
// 0   | digit 0 (rightmost) slot
// 1   | digit 1 slot
// 2   | digit 2 slot, carries the stopwatch dot
// 3   | digit 3 slot, frame latch on its terminal tick
module fnd_scan_ctrl
   import fnd_pkg::*;
#(
   parameter int SCAN_DIV  = 100_000,
   parameter int DOT_TICKS = 500
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        sel,
   input  logic [15:0] i_sw_bcd,
   input  logic [15:0] i_us_bcd,
   output logic [3:0]  o_fndcom,
   output logic [7:0]  o_fndfont,
   output logic        o_active_sel
);

   localparam int PW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
   localparam int DW = (DOT_TICKS > 2) ? $clog2(DOT_TICKS) : 1;
   localparam logic [PW-1:0] PRE_LOAD = PW'(SCAN_DIV - 1);
   localparam logic [DW-1:0] DOT_LOAD = DW'(DOT_TICKS - 1);

   localparam logic [1:0] DIG0 = 2'd0;
   localparam logic [1:0] DIG1 = 2'd1;
   localparam logic [1:0] DIG2 = 2'd2;
   localparam logic [1:0] DIG3 = 2'd3;

   logic          started;
   logic [PW-1:0] pre_cnt;
   logic          tick;
   logic [1:0]    idx;
   logic [DW-1:0] dot_cnt;
   logic          dot_phase;
   logic [15:0]   snapshot;
   logic          active_sel;
   logic          latch;
   logic [3:0]    nib;
   logic [6:0]    seg;
   logic          blank;
   logic [7:0]    font_nxt;

   // The first edge out of reset only latches the frame; slot timing starts after it,
   // so the first displayed digit is held a full slot like every other.
   assign tick  = started && (pre_cnt == '0);
   assign latch = !started || (tick && (idx == DIG3));

   always_ff @(posedge clk) begin
      if (reset) begin
         started    <= 1'b0;
         pre_cnt    <= PRE_LOAD;
         idx        <= DIG0;
         dot_cnt    <= DOT_LOAD;
         dot_phase  <= 1'b0;
         snapshot   <= '0;
         active_sel <= 1'b0;
      end else begin
         started <= 1'b1;
         if (started) pre_cnt <= (pre_cnt == '0) ? PRE_LOAD : pre_cnt - PW'(1);
         if (tick) begin
            idx <= idx + 2'd1;
            if (dot_cnt == '0) begin
               dot_cnt   <= DOT_LOAD;
               dot_phase <= ~dot_phase;
            end else begin
               dot_cnt <= dot_cnt - DW'(1);
            end
         end
         if (latch) begin
            active_sel <= sel;
            snapshot   <= sel ? i_us_bcd : i_sw_bcd;
         end
      end
   end

   assign nib = snapshot[{idx, 2'b00} +: 4];

   fnd_bcd_decoder u_dec (
      .bcd (nib),
      .seg (seg)
   );

   // A digit is leading-zero only if it and every digit to its left are zero.
   always_comb begin
      blank = 1'b0;
      case (idx)
         DIG0:    blank = 1'b0;
         DIG1:    blank = (snapshot[15:4] == 12'h000);
         DIG2:    blank = (snapshot[15:8] == 8'h00);
         DIG3:    blank = (snapshot[15:12] == 4'h0);
         default: blank = 1'b0;
      endcase
      blank = blank && active_sel;
   end

   always_comb begin
      font_nxt = {1'b1, seg};
      if (!active_sel && (idx == DIG2) && dot_phase) font_nxt[DP_BIT] = 1'b0;
      if (blank) font_nxt = FONT_BLANK;
   end

   always_ff @(posedge clk) begin
      if (reset || !started) begin
         o_fndcom     <= COM_OFF;
         o_fndfont    <= FONT_BLANK;
         o_active_sel <= 1'b0;
      end else begin
         o_fndcom     <= COM_CODE[idx];
         o_fndfont    <= font_nxt;
         o_active_sel <= active_sel;
      end
   end

endmodule

// File: tb/tb_fnd_scan_ctrl.sv
// Bench for fnd_scan_ctrl: a cycle-count model of the scan checked every cycle,
// plus hand-computed digit/font expectations for each scenario.
module tb_fnd_scan_ctrl;

   localparam int SD    = 4;
   localparam int DT    = 3;
   localparam int FRAME = 4 * SD;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        sel = 1'b0;
   logic [15:0] sw_bcd = 16'h0000;
   logic [15:0] us_bcd = 16'h0000;
   logic [3:0]  o_fndcom;
   logic [7:0]  o_fndfont;
   logic        o_active_sel;

   int errors = 0;
   int checks = 0;

   // model: mk = index of the last edge since reset release (E0 = 0, -1 in reset)
   int          mk = -1;
   bit          m_valid = 1'b0;
   logic [15:0] m_snap = 16'h0000;
   logic        m_us = 1'b0;
   logic [3:0]  e_com = 4'hF;
   logic [7:0]  e_font = 8'hFF;
   logic        e_sel = 1'b0;

   logic [7:0] font_tab [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

   fnd_scan_ctrl #(.SCAN_DIV(SD), .DOT_TICKS(DT)) dut (
      .clk          (clk),
      .reset        (reset),
      .sel          (sel),
      .i_sw_bcd     (sw_bcd),
      .i_us_bcd     (us_bcd),
      .o_fndcom     (o_fndcom),
      .o_fndfont    (o_fndfont),
      .o_active_sel (o_active_sel)
   );

   always #5 clk = ~clk;

   function automatic logic [3:0] model_com(int k);
      int d;
      if (k <= 0) return 4'b1111;
      d = ((k - 1) / SD) % 4;
      return ~(4'b0001 << d);
   endfunction

   function automatic logic [7:0] model_font(int k, logic [15:0] v, logic us);
      int s, d, n;
      bit ph, lead;
      logic [7:0] f;
      if (k <= 0) return 8'hFF;
      s  = (k - 1) / SD;
      d  = s % 4;
      ph = ((s / DT) % 2) == 1;
      n  = int'((v >> (4 * d)) & 16'h000F);
      f  = (n < 10) ? font_tab[n] : 8'hBF;
      if (us) begin
         lead = (d > 0);
         for (int j = d; j < 4; j++)
            if (((v >> (4 * j)) & 16'h000F) != 16'h0000) lead = 1'b0;
         if (lead) f = 8'hFF;
      end else if (d == 2 && ph) begin
         f[7] = 1'b0;
      end
      return f;
   endfunction

   always @(posedge clk) begin
      m_valid <= 1'b1;
      if (reset) begin
         mk     <= -1;
         e_com  <= 4'b1111;
         e_font <= 8'hFF;
         e_sel  <= 1'b0;
      end else begin
         mk     <= mk + 1;
         e_com  <= model_com(mk + 1);
         e_font <= model_font(mk + 1, m_snap, m_us);
         e_sel  <= (mk + 1 == 0) ? 1'b0 : m_us;
         if ((mk + 1) % FRAME == 0) begin
            m_snap <= sel ? us_bcd : sw_bcd;
            m_us   <= sel;
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s (k=%0d t=%0t): got %h expected %h", name, mk, $time, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (m_valid) begin
         chk("model_com",  32'(o_fndcom),     32'(e_com));
         chk("model_font", 32'(o_fndfont),    32'(e_font));
         chk("model_sel",  32'(o_active_sel), 32'(e_sel));
      end
   end

   task automatic wait_k(input int target);
      int budget = 400;
      while (mk != target && budget > 0) begin
         @(negedge clk);
         budget--;
      end
      checks++;
      if (mk != target) begin
         errors++;
         $display("FAIL wait_k timeout: at k=%0d expected k=%0d", mk, target);
      end
   endtask

   task automatic lit(input string name, input int k, input logic [3:0] com, input logic [7:0] font,
                      input logic asel);
      wait_k(k);
      chk({name, "_com"},  32'(o_fndcom),     32'(com));
      chk({name, "_font"}, 32'(o_fndfont),    32'(font));
      chk({name, "_sel"},  32'(o_active_sel), 32'(asel));
   endtask

   task automatic restart(input logic s, input logic [15:0] sw, input logic [15:0] us);
      @(negedge clk);
      reset = 1'b1;
      sel = s;
      sw_bcd = sw;
      us_bcd = us;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
   endtask

   initial begin
      repeat (3) @(negedge clk);
      chk("reset_com",  32'(o_fndcom),     32'h0000_000F);
      chk("reset_font", 32'(o_fndfont),    32'h0000_00FF);
      chk("reset_sel",  32'(o_active_sel), 32'h0000_0000);

      // basic stopwatch scan
      restart(1'b0, 16'h1234, 16'h0000);
      lit("sw_d0",  1, 4'b1110, 8'h99, 1'b0);
      lit("sw_d0b", 4, 4'b1110, 8'h99, 1'b0);
      lit("sw_d1",  5, 4'b1101, 8'hB0, 1'b0);
      lit("sw_d2",  9, 4'b1011, 8'hA4, 1'b0);
      lit("sw_d3", 13, 4'b0111, 8'hF9, 1'b0);
      lit("sw_rep",17, 4'b1110, 8'h99, 1'b0);

      // stopwatch dot blinking over 24 slots
      restart(1'b0, 16'h0000, 16'h0000);
      lit("dot_s2",   9, 4'b1011, 8'hC0, 1'b0);
      lit("dot_s4",  17, 4'b1110, 8'hC0, 1'b0);
      lit("dot_s10", 41, 4'b1011, 8'h40, 1'b0);
      lit("dot_s14", 57, 4'b1011, 8'hC0, 1'b0);
      lit("dot_s22", 89, 4'b1011, 8'h40, 1'b0);
      wait_k(97);

      // ultrasonic leading-zero blanking
      restart(1'b1, 16'h0000, 16'h0007);
      lit("us7_d0",  1, 4'b1110, 8'hF8, 1'b1);
      lit("us7_d1",  5, 4'b1101, 8'hFF, 1'b1);
      lit("us7_d2",  9, 4'b1011, 8'hFF, 1'b1);
      lit("us7_d3", 13, 4'b0111, 8'hFF, 1'b1);
      us_bcd = 16'h0105;
      lit("us105_d0", 17, 4'b1110, 8'h92, 1'b1);
      lit("us105_d1", 21, 4'b1101, 8'hC0, 1'b1);
      lit("us105_d2", 25, 4'b1011, 8'hF9, 1'b1);
      lit("us105_d3", 29, 4'b0111, 8'hFF, 1'b1);
      us_bcd = 16'h0000;
      lit("us0_d0", 33, 4'b1110, 8'hC0, 1'b1);
      lit("us0_d1", 37, 4'b1101, 8'hFF, 1'b1);
      lit("us0_d2", 41, 4'b1011, 8'hFF, 1'b1);

      // source switch mid-frame takes effect at the next frame
      restart(1'b0, 16'h1234, 16'h5678);
      wait_k(5);
      sel = 1'b1;
      lit("sw2us_d2",  9, 4'b1011, 8'hA4, 1'b0);
      lit("sw2us_d3", 13, 4'b0111, 8'hF9, 1'b0);
      lit("sw2us_d0", 17, 4'b1110, 8'h80, 1'b1);
      lit("sw2us_d1", 21, 4'b1101, 8'hF8, 1'b1);

      // invalid BCD renders as dash
      restart(1'b0, 16'hA00F, 16'h0000);
      lit("inv_d0",  1, 4'b1110, 8'hBF, 1'b0);
      lit("inv_d1",  5, 4'b1101, 8'hC0, 1'b0);
      lit("inv_d3", 13, 4'b0111, 8'hBF, 1'b0);

      // reset mid-scan, then a clean restart
      restart(1'b0, 16'h1234, 16'h0000);
      wait_k(10);
      reset = 1'b1;
      @(negedge clk);
      chk("midrst_com",  32'(o_fndcom),  32'h0000_000F);
      chk("midrst_font", 32'(o_fndfont), 32'h0000_00FF);
      @(negedge clk);
      reset = 1'b0;
      lit("rst_d0", 1, 4'b1110, 8'h99, 1'b0);
      lit("rst_d1", 5, 4'b1101, 8'hB0, 1'b0);
      wait_k(20);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
